// File: rtl/data_ram_responder.sv
// -----------------------------------------------------------------------------
// data_ram_responder
//
// Memory-side responder for the single-cycle CPU data port. Loads are served
// combinationally in the same cycle as the address; stores commit at the
// rising edge of sys_clk. Holds a word-addressed RAM of 2^ADDR_W 32-bit words
// and a sticky store-fault logger. When the macro DMEM_MMIO_EN is defined, a
// register page at 0xFFFF_0000 adds a GPIO output register, a free-running
// cycle counter, a saturating store counter and fault status/clear access.
//
// Parameters:
//   ADDR_W      word-address bits of the RAM (default 10 -> 4 KiB)
//
// Ports:
//   sys_clk     in   1   system clock, rising-edge active
//   sys_rst     in   1   synchronous active-high reset
//   daddr       in   32  byte address from the CPU
//   din         in   32  store data from the CPU
//   MemWrite    in   1   store strobe
//   dout        out  32  load data, combinational from daddr and state
//   gpio_out    out  32  GPIO register (0 when DMEM_MMIO_EN is undefined)
//   fault       out  1   sticky store-fault flag
//   fault_addr  out  32  address of the first faulting store since last clear
//
// Optional feature macro: DMEM_MMIO_EN
// -----------------------------------------------------------------------------
module data_ram_responder #(
  parameter int ADDR_W = 10
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [31:0] daddr,
  input  logic [31:0] din,
  input  logic        MemWrite,
  output logic [31:0] dout,
  output logic [31:0] gpio_out,
  output logic        fault,
  output logic [31:0] fault_addr
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Saturating increment: the store counter sticks at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0]       r_mem [0:DEPTH-1];
  logic              r_fault;
  logic [31:0]       r_fault_addr;

  logic              w_is_mmio;
  logic              w_is_ram;
  logic              w_aligned;
  logic [ADDR_W-1:0] w_idx;
  logic              w_ram_we;
  logic              w_st_fault;
  logic [31:0]       w_dout;

  assign w_aligned = (daddr[1:0] == 2'b00);
  assign w_idx     = daddr[ADDR_W+1:2];

`ifdef DMEM_MMIO_EN
  logic [31:0] r_gpio;
  logic [31:0] r_cycle;
  logic [31:0] r_store_cnt;
  logic        w_mmio_def;
  logic        w_wr_gpio;
  logic        w_wr_cycle;
  logic        w_clr_fault;

  assign w_is_mmio  = (daddr[31:16] == 16'hFFFF);
  assign w_mmio_def = w_is_mmio &&
                      ((daddr[15:0] == 16'h0000) || (daddr[15:0] == 16'h0004) ||
                       (daddr[15:0] == 16'h0008) || (daddr[15:0] == 16'h000C) ||
                       (daddr[15:0] == 16'h0010));
  assign w_wr_gpio   = MemWrite && w_is_mmio && (daddr[15:0] == 16'h0000);
  assign w_wr_cycle  = MemWrite && w_is_mmio && (daddr[15:0] == 16'h0004);
  assign w_clr_fault = MemWrite && w_is_mmio && (daddr[15:0] == 16'h000C) && din[0];
`else
  assign w_is_mmio = 1'b0;
`endif

  // MMIO decode takes priority, so the page never aliases onto RAM.
  assign w_is_ram = !w_is_mmio && (daddr[31:ADDR_W+2] == '0);

  // Misaligned stores fault anywhere; aligned stores fault only when they hit
  // neither RAM nor the MMIO page (undefined MMIO offsets drop silently).
  assign w_st_fault = MemWrite && (!w_aligned || (!w_is_ram && !w_is_mmio));
  assign w_ram_we   = MemWrite && !sys_rst && w_aligned && w_is_ram;

  // RAM array: never reset, write gated off during reset.
  always_ff @(posedge sys_clk) begin
    if (w_ram_we) begin
      r_mem[w_idx] <= din;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else if (w_st_fault) begin
      r_fault <= 1'b1;
      if (!r_fault) begin
        r_fault_addr <= daddr;
      end
`ifdef DMEM_MMIO_EN
    end else if (w_clr_fault) begin
      r_fault <= 1'b0;
`endif
    end
  end

`ifdef DMEM_MMIO_EN
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_gpio      <= '0;
      r_cycle     <= '0;
      r_store_cnt <= '0;
    end else begin
      if (w_wr_gpio) begin
        r_gpio <= din;
      end
      // A CYCLE store replaces the increment for that edge only.
      if (w_wr_cycle) begin
        r_cycle <= din;
      end else begin
        r_cycle <= r_cycle + 32'd1;
      end
      if (w_ram_we) begin
        r_store_cnt <= sat_inc(r_store_cnt);
      end
    end
  end

  assign gpio_out = r_gpio;
`else
  assign gpio_out = '0;
`endif

  // Load path: old contents are visible during a same-address store.
  always_comb begin
    w_dout = '0;
    if (w_is_ram) begin
      w_dout = r_mem[w_idx];
`ifdef DMEM_MMIO_EN
    end else if (w_mmio_def) begin
      case (daddr[15:0])
        16'h0000: w_dout = r_gpio;
        16'h0004: w_dout = r_cycle;
        16'h0008: w_dout = r_store_cnt;
        16'h000C: w_dout = {31'd0, r_fault};
        16'h0010: w_dout = r_fault_addr;
        default:  w_dout = '0;
      endcase
`endif
    end
  end

  assign dout       = w_dout;
  assign fault      = r_fault;
  assign fault_addr = r_fault_addr;

endmodule

// File: tb/tb_data_ram_responder.sv
module tb_data_ram_responder;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [31:0] daddr;
  logic [31:0] din;
  logic        MemWrite;
  logic [31:0] dout;
  logic [31:0] gpio_out;
  logic        fault;
  logic [31:0] fault_addr;

  data_ram_responder #(.ADDR_W(10)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .daddr      (daddr),
    .din        (din),
    .MemWrite   (MemWrite),
    .dout       (dout),
    .gpio_out   (gpio_out),
    .fault      (fault),
    .fault_addr (fault_addr)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        mw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_dout;
    logic [31:0] exp_dout;
    logic        exp_fault;
    logic [31:0] exp_faddr;
    logic [31:0] exp_gpio;
  } vec_t;

  vec_t q_exp[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Expectations describe what is visible in the cycle the inputs are
  // presented, i.e. before that cycle's store commits.
  task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d,
                      input logic cd, input logic [31:0] ed, input logic ef,
                      input logic [31:0] efa, input logic [31:0] eg);
    vec_t v;
    vec_t e;
    v.mw = mw; v.addr = a; v.wdata = d; v.chk_dout = cd; v.exp_dout = ed;
    v.exp_fault = ef; v.exp_faddr = efa; v.exp_gpio = eg;
    MemWrite = mw;
    daddr    = a;
    din      = d;
    q_exp.push_back(v);
    @(negedge sys_clk);
    e = q_exp.pop_front();
    n_vec++;
    if (e.chk_dout && dout !== e.exp_dout) begin
      n_bad++;
      $display("FAIL dout @%h: got %h want %h", e.addr, dout, e.exp_dout);
    end
    if (fault !== e.exp_fault) begin
      n_bad++;
      $display("FAIL fault @%h: got %b want %b", e.addr, fault, e.exp_fault);
    end
    if (fault_addr !== e.exp_faddr) begin
      n_bad++;
      $display("FAIL fault_addr @%h: got %h want %h", e.addr, fault_addr, e.exp_faddr);
    end
    if (gpio_out !== e.exp_gpio) begin
      n_bad++;
      $display("FAIL gpio_out @%h: got %h want %h", e.addr, gpio_out, e.exp_gpio);
    end
    @(posedge sys_clk);
    #1;
  endtask

  vec_t tbl[15];

  initial begin
    // {mw, addr, wdata, chk_dout, exp_dout, exp_fault, exp_faddr, exp_gpio}
    tbl[0]  = '{1'b1, 32'h0000_0000, 32'hAAAA_5555, 1'b0, 32'h0,         1'b0, 32'h0, 32'h0};
    tbl[1]  = '{1'b1, 32'h0000_0010, 32'h1111_1111, 1'b0, 32'h0,         1'b0, 32'h0, 32'h0};
    tbl[2]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'h1111_1111, 1'b0, 32'h0, 32'h0};
    tbl[3]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0};
    tbl[4]  = '{1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0};
    tbl[5]  = '{1'b1, 32'h0000_0004, 32'h0123_4567, 1'b0, 32'h0,         1'b0, 32'h0, 32'h0};
    tbl[6]  = '{1'b0, 32'h0000_0002, 32'h0,         1'b1, 32'hAAAA_5555, 1'b0, 32'h0, 32'h0};
    tbl[7]  = '{1'b0, 32'h8000_0000, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0, 32'h0};
    tbl[8]  = '{1'b0, 32'hFFFF_0020, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0, 32'h0};
    tbl[9]  = '{1'b0, 32'h0000_1000, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0, 32'h0};
    tbl[10] = '{1'b1, 32'h0000_0006, 32'hCAFE_F00D, 1'b1, 32'h0123_4567, 1'b0, 32'h0, 32'h0};
    tbl[11] = '{1'b0, 32'h0000_0007, 32'h0,         1'b1, 32'h0123_4567, 1'b1, 32'h6, 32'h0};
    tbl[12] = '{1'b1, 32'h0000_1000, 32'h0000_0005, 1'b1, 32'h0,         1'b1, 32'h6, 32'h0};
    tbl[13] = '{1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'hAAAA_5555, 1'b1, 32'h6, 32'h0};
    tbl[14] = '{1'b0, 32'h0000_0004, 32'h0,         1'b1, 32'h0123_4567, 1'b1, 32'h6, 32'h0};

    sys_rst  = 1'b1;
    MemWrite = 1'b0;
    daddr    = '0;
    din      = '0;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;

    // Reset state
    step(1'b0, 32'h8000_0000, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].mw, tbl[i].addr, tbl[i].wdata, tbl[i].chk_dout, tbl[i].exp_dout,
           tbl[i].exp_fault, tbl[i].exp_faddr, tbl[i].exp_gpio);
    end

`ifdef DMEM_MMIO_EN
    // Fault status readback and clear; fault_addr is retained after the clear.
    step(1'b1, 32'hFFFF_000C, 32'h1, 1'b1, 32'h1, 1'b1, 32'h6, 32'h0);
    step(1'b0, 32'hFFFF_0010, 32'h0, 1'b1, 32'h6, 1'b0, 32'h6, 32'h0);
    step(1'b0, 32'hFFFF_000C, 32'h0, 1'b1, 32'h0, 1'b0, 32'h6, 32'h0);
    // Undefined MMIO store: dropped, no fault
    step(1'b1, 32'hFFFF_0020, 32'h7, 1'b1, 32'h0, 1'b0, 32'h6, 32'h0);
    step(1'b0, 32'hFFFF_0020, 32'h0, 1'b1, 32'h0, 1'b0, 32'h6, 32'h0);
    // GPIO
    step(1'b1, 32'hFFFF_0000, 32'hA5, 1'b1, 32'h0,  1'b0, 32'h6, 32'h0);
    step(1'b0, 32'hFFFF_0000, 32'h0,  1'b1, 32'hA5, 1'b0, 32'h6, 32'hA5);
`endif

    // One-cycle reset with a store presented: store discarded, RAM kept.
    sys_rst  = 1'b1;
    MemWrite = 1'b1;
    daddr    = 32'h0000_0010;
    din      = 32'h0BAD_0BAD;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;

`ifdef DMEM_MMIO_EN
    // CYCLE reads 0 in the first cycle after release, then counts up.
    for (int k = 0; k <= 5; k++) begin
      step(1'b0, 32'hFFFF_0004, 32'h0, 1'b1, k, 1'b0, 32'h0, 32'h0);
    end
    step(1'b1, 32'hFFFF_0004, 32'hFFFF_FFFE, 1'b1, 32'h6, 1'b0, 32'h0, 32'h0);
    step(1'b0, 32'hFFFF_0004, 32'h0, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0, 32'h0);
    step(1'b0, 32'hFFFF_0004, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0);
    step(1'b0, 32'hFFFF_0004, 32'h0, 1'b1, 32'h0,         1'b0, 32'h0, 32'h0);
    // STORE_CNT: reset to 0, ignores stores, counts accepted RAM stores only.
    step(1'b1, 32'hFFFF_0008, 32'h55, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h0000_0020, 32'h1,  1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h0000_0024, 32'h2,  1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h0000_0029, 32'h9,  1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h0000_0028, 32'h3,  1'b1, 32'h0, 1'b1, 32'h29, 32'h0);
    step(1'b0, 32'hFFFF_0008, 32'h0,  1'b1, 32'h3, 1'b1, 32'h29, 32'h0);
    step(1'b0, 32'hFFFF_0010, 32'h0,  1'b1, 32'h29, 1'b1, 32'h29, 32'h0);
`else
    // Without the MMIO page, 0xFFFF_xxxx stores are out-of-range faults.
    step(1'b0, 32'h0000_0010, 32'h0,  1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'hFFFF_0000, 32'hA5, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 32'hFFFF_0000, 32'h0,  1'b1, 32'h0, 1'b1, 32'hFFFF_0000, 32'h0);
    step(1'b1, 32'hFFFF_000C, 32'h1,  1'b1, 32'h0, 1'b1, 32'hFFFF_0000, 32'h0);
    step(1'b0, 32'hFFFF_000C, 32'h0,  1'b1, 32'h0, 1'b1, 32'hFFFF_0000, 32'h0);
`endif

    // RAM contents survive reset; the discarded store left 0x10 unchanged.
    step(1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'hDEAD_BEEF, fault, fault_addr, gpio_out);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
